axi_burst_writer: RTL and testbench

AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

---
 rtl/axi_burst_writer.sv | 199 +++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_writer.sv
// axi_burst_writer: buffers 16-bit words and emits fixed-length AXI INCR write bursts.
// Define BRESP_WAIT_EN to wait for the write response after each burst.
module axi_burst_writer #(
  parameter int          BURST_LEN  = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [21:0] BASE_ADDR  = 22'h000000,
  parameter logic [21:0] END_ADDR   = 22'h3FFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  axi_awid,
  output logic [21:0] axi_awaddr,
  output logic [7:0]  axi_awlen,
  output logic [2:0]  axi_awsize,
  output logic [1:0]  axi_awburst,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [15:0] axi_wdata,
  output logic [1:0]  axi_wstrb,
  output logic        axi_wvalid,
  output logic        axi_wlast,
  input  logic        axi_wready,
  input  logic [7:0]  axi_bid,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic        busy,
  output logic [15:0] burst_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BL_C = CW'(BURST_LEN);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);
  localparam logic [22:0] BL_A = 23'(BURST_LEN);
  localparam logic [22:0] END_A = {1'b0, END_ADDR};

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } state_t;

  state_t state;

  logic [15:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic rdy_en;
  logic push;
  logic pop;

  logic [21:0] addr;
  logic [22:0] addr_inc;
  logic [21:0] addr_nxt;
  logic [2:0] beat;

  assign axi_awid = 8'h00;
  assign axi_awlen = 8'(BURST_LEN - 1);
  assign axi_awsize = 3'b001;
  assign axi_awburst = 2'b01;
  assign axi_wstrb = 2'b11;

  assign in_ready = rdy_en && (count != DEPTH_C);
  assign push = in_valid && in_ready;
  assign pop = axi_wvalid && axi_wready && (count != '0);

  // Head word is shown only while a beat is offered; zero otherwise.
  assign axi_wdata = axi_wvalid ? mem[rd_ptr] : 16'h0000;

`ifdef BRESP_WAIT_EN
  logic bready_q;
  logic unused_b;
  assign axi_bready = bready_q;
  assign unused_b = ^axi_bid;
`else
  logic unused_b;
  assign axi_bready = rdy_en;
  assign unused_b = ^{axi_bid, axi_bvalid};
`endif

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PONE;
      end
      case ({push, pop})
        2'b10: count <= count + ONE_C;
        2'b01: count <= count - ONE_C;
        default: ;
      endcase
    end
  end

  // Next burst address, wrapping when the next burst would pass END_ADDR.
  always_comb begin
    addr_inc = {1'b0, addr} + BL_A;
    addr_nxt = addr_inc[21:0];
    if (addr_inc + BL_A - 23'd1 > END_A) begin
      addr_nxt = BASE_ADDR;
    end
  end

  // Burst sequencer with registered AXI handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr <= BASE_ADDR;
      burst_count <= 16'h0000;
      beat <= 3'd0;
      axi_awvalid <= 1'b0;
      axi_awaddr <= BASE_ADDR;
      axi_wvalid <= 1'b0;
      axi_wlast <= 1'b0;
      busy <= 1'b0;
`ifdef BRESP_WAIT_EN
      bready_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && count >= BL_C) begin
            state <= AW;
            axi_awvalid <= 1'b1;
            axi_awaddr <= addr;
            busy <= 1'b1;
          end
        end
        AW: begin
          if (axi_awready) begin
            state <= W;
            axi_awvalid <= 1'b0;
            axi_wvalid <= 1'b1;
            axi_wlast <= (LAST_BEAT == 3'd0);
            beat <= 3'd0;
          end
        end
        W: begin
          if (axi_wready) begin
            if (beat == LAST_BEAT) begin
              axi_wvalid <= 1'b0;
              axi_wlast <= 1'b0;
              addr <= addr_nxt;
              burst_count <= burst_count + 16'd1;
`ifdef BRESP_WAIT_EN
              state <= B;
              bready_q <= 1'b1;
`else
              state <= IDLE;
              busy <= 1'b0;
`endif
            end else begin
              beat <= beat + 3'd1;
              axi_wlast <= (beat + 3'd1 == LAST_BEAT);
            end
          end
        end
`ifdef BRESP_WAIT_EN
        B: begin
          if (axi_bvalid && bready_q) begin
            state <= IDLE;
            bready_q <= 1'b0;
            busy <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_writer.sv
// tb_axi_burst_writer: table vectors, directed sequences and random traffic
// checked against a queue-based model of the burst writer.
module tb_axi_burst_writer;

  localparam int BL = 8;
  localparam int FD = 16;
  localparam logic [21:0] BASE = 22'h000000;
  localparam logic [21:0] ENDA = 22'h00000F;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [15:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [7:0] axi_awid;
  logic [21:0] axi_awaddr;
  logic [7:0] axi_awlen;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst;
  logic axi_awvalid;
  logic axi_awready;
  logic [15:0] axi_wdata;
  logic [1:0] axi_wstrb;
  logic axi_wvalid;
  logic axi_wlast;
  logic axi_wready;
  logic [7:0] axi_bid;
  logic axi_bvalid;
  logic axi_bready;
  logic busy;
  logic [15:0] burst_count;

  axi_burst_writer #(
    .BURST_LEN(BL),
    .FIFO_DEPTH(FD),
    .BASE_ADDR(BASE),
    .END_ADDR(ENDA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid),
    .axi_wlast(axi_wlast),
    .axi_wready(axi_wready),
    .axi_bid(axi_bid),
    .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .busy(busy),
    .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, want event within bound (t=%0t)", nm, $time);
  endtask

  function automatic logic [21:0] exp_addr(input int n);
    int slots;
    slots = (int'(ENDA) - int'(BASE) + 1) / BL;
    return BASE + 22'((n % slots) * BL);
  endfunction

  // Reference model state
  logic [15:0] exp_q[$];
  logic [15:0] beat_log[$];
  bit last_log[$];
  logic [21:0] aw_log[$];
  int occ, beat, done, aw_cnt, cyc, done_cyc;
  bit aw_open, b_wait, aw_seen;
  bit st_aw, st_w, go_chk, go_exp;
  logic [21:0] prev_awaddr;
  logic [15:0] prev_wdata;
  logic tb_edge;

  always @(posedge clk or negedge reset) begin
    if (!reset) tb_edge <= 1'b0;
    else tb_edge <= 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_awvalid", axi_awvalid, 0);
      chk("rst_wvalid", axi_wvalid, 0);
      chk("rst_wlast", axi_wlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bready", axi_bready, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_awaddr", axi_awaddr, BASE);
      chk("rst_wdata", axi_wdata, 0);
      chk("rst_bcount", burst_count, 0);
      exp_q.delete();
      beat_log.delete();
      last_log.delete();
      aw_log.delete();
      occ = 0; beat = 0; done = 0; aw_cnt = 0;
      aw_open = 0; b_wait = 0; aw_seen = 0;
      st_aw = 0; st_w = 0; go_chk = 0;
    end else begin
      if (st_aw) begin
        chk("aw_hold_valid", axi_awvalid, 1);
        chk("aw_hold_addr", axi_awaddr, prev_awaddr);
      end
      if (st_w) begin
        chk("w_hold_valid", axi_wvalid, 1);
        chk("w_hold_data", axi_wdata, prev_wdata);
      end
      if (go_chk) chk("aw_start", axi_awvalid, go_exp);
      chk("aw_w_excl", axi_awvalid && axi_wvalid, 0);
      chk("aw_excl", axi_awvalid && (aw_open || b_wait), 0);
      chk("wvalid", axi_wvalid, aw_open);
      chk("busy", busy, axi_awvalid || aw_open || b_wait);
      chk("in_ready", in_ready, tb_edge && (occ < FD));
      chk("burst_count", burst_count, 16'(done));
`ifdef BRESP_WAIT_EN
      chk("bready", axi_bready, b_wait);
`else
      chk("bready", axi_bready, tb_edge);
`endif
      if (axi_wvalid) chk("wlast", axi_wlast, beat == BL - 1);
      else chk("wlast_idle", axi_wlast, 0);

      st_aw = axi_awvalid && !axi_awready;
      prev_awaddr = axi_awaddr;
      st_w = axi_wvalid && !axi_wready;
      prev_wdata = axi_wdata;
      go_chk = !busy;
      go_exp = enable && (occ >= BL);
      if (axi_awvalid) aw_seen = 1;

      if (axi_awvalid && axi_awready) begin
        chk("aw_addr", axi_awaddr, exp_addr(aw_cnt));
        chk("aw_len", axi_awlen, BL - 1);
        chk("aw_size", axi_awsize, 1);
        chk("aw_burst", axi_awburst, 1);
        chk("aw_id", axi_awid, 0);
`ifdef BRESP_WAIT_EN
        if (aw_cnt > 0) chk("b_gap", (cyc - done_cyc) > 10, 1);
`endif
        aw_log.push_back(axi_awaddr);
        aw_cnt++;
        aw_open = 1;
        beat = 0;
      end
`ifdef BRESP_WAIT_EN
      if (axi_bvalid && axi_bready) b_wait = 0;
`endif
      if (axi_wvalid && axi_wready) begin
        chk("wstrb", axi_wstrb, 2'b11);
        if (exp_q.size() == 0) begin
          fail("w_underflow");
        end else begin
          chk("wdata", axi_wdata, exp_q.pop_front());
          occ--;
        end
        beat_log.push_back(axi_wdata);
        last_log.push_back(axi_wlast);
        if (beat == BL - 1) begin
          beat = 0;
          aw_open = 0;
          done++;
          done_cyc = cyc;
`ifdef BRESP_WAIT_EN
          b_wait = 1;
`endif
        end else begin
          beat++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        occ++;
      end
    end
  end

  // Handshake drivers for ready inputs and the write response
  bit auto_drv = 0;
  int stall_pct = 0;
  int aw_stall = 0;
  int bcnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_drv) begin
        axi_wready = $urandom_range(0, 99) >= stall_pct;
        axi_awready = $urandom_range(0, 99) >= aw_stall;
      end
    end
  end

  initial begin
    axi_bvalid = 1'b0;
    axi_bid = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      axi_bid = 8'($urandom);
`ifdef BRESP_WAIT_EN
      if (!axi_bready || !reset) begin
        axi_bvalid = 1'b0;
        bcnt = 0;
      end else if (bcnt >= 10) begin
        axi_bvalid = 1'b1;
      end else begin
        bcnt++;
      end
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    auto_drv = 0;
    in_valid = 0;
    enable = 0;
    axi_awready = 0;
    axi_wready = 0;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic push_n(input int n, input bit seq, input logic [15:0] first);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data = seq ? first + 16'(i) : 16'($urandom);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) begin
        fail("push_timeout");
        in_valid = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_beats(input int n, input string nm);
    int t;
    t = 0;
    while (beat_log.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (beat_log.size() < n) fail(nm);
  endtask

  typedef struct {
    int nwords;
    bit en;
    int stall;
    int exp_bursts;
    bit exp_rdy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int acc;
    bit found;
    logic [21:0] wrap_exp [3];
    reset = 0;
    enable = 0;
    in_data = 0;
    in_valid = 0;
    axi_awready = 0;
    axi_wready = 0;

    tbl = '{
      '{7, 1, 0, 0, 1},
      '{8, 1, 0, 1, 1},
      '{16, 1, 50, 2, 1},
      '{8, 0, 0, 0, 1},
      '{12, 1, 30, 1, 1},
      '{16, 0, 0, 0, 0},
      '{23, 1, 20, 2, 1}
    };

    for (int i = 0; i < 7; i++) begin
      do_reset();
      enable = tbl[i].en;
      stall_pct = tbl[i].stall;
      aw_stall = 0;
      auto_drv = 1;
      push_n(tbl[i].nwords, 0, 16'h0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("tbl_bursts", burst_count, tbl[i].exp_bursts);
      chk("tbl_aw_count", aw_cnt, tbl[i].exp_bursts);
      chk("tbl_in_ready", in_ready, tbl[i].exp_rdy);
      chk("tbl_busy", busy, 0);
    end

    // Single burst with known data
    do_reset();
    enable = 1; axi_awready = 1; axi_wready = 1;
    push_n(8, 1, 16'h0001);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("s1_beats", beat_log.size(), 8);
    for (int i = 0; i < 8 && i < beat_log.size(); i++) begin
      chk("s1_data", beat_log[i], i + 1);
      chk("s1_wlast", last_log[i], i == 7);
    end
    chk("s1_aw_n", aw_log.size(), 1);
    if (aw_log.size() > 0) chk("s1_awaddr", aw_log[0], 22'h000000);
    chk("s1_bcount", burst_count, 1);

    // Threshold: seven words never start a burst, the eighth does
    do_reset();
    enable = 1; axi_awready = 1; axi_wready = 1;
    push_n(7, 0, 16'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("s2_no_aw", aw_seen, 0);
    @(posedge clk);
    #1;
    push_n(1, 0, 16'h0);
    found = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (axi_awvalid) found = 1;
    end
    chk("s2_aw_latency", found, 1);
    repeat (30) @(posedge clk);

    // Write stall mid-burst with concurrent pushes
    do_reset();
    enable = 1; axi_awready = 1; axi_wready = 1;
    push_n(8, 1, 16'h0100);
    wait_beats(3, "s3_wait");
    @(posedge clk);
    #1;
    fork
      begin
        axi_wready = 0;
        repeat (5) @(posedge clk);
        #1;
        axi_wready = 1;
      end
      push_n(2, 1, 16'h0200);
    join
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("s3_beats", beat_log.size(), 8);
    for (int i = 0; i < 8 && i < beat_log.size(); i++) begin
      chk("s3_data", beat_log[i], 16'h0100 + 16'(i));
    end
    chk("s3_bcount", burst_count, 1);

    // Address wrap over three bursts
    do_reset();
    enable = 1; axi_awready = 1; axi_wready = 1;
    push_n(24, 0, 16'h0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    wrap_exp = '{22'h000000, 22'h000008, 22'h000000};
    chk("s4_aw_n", aw_log.size(), 3);
    for (int i = 0; i < 3 && i < aw_log.size(); i++) begin
      chk("s4_awaddr", aw_log[i], wrap_exp[i]);
    end
    chk("s4_bcount", burst_count, 3);

    // Backpressure: sixteen words fill the buffer
    do_reset();
    enable = 1; axi_awready = 1; axi_wready = 0;
    in_valid = 1;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      in_data = 16'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("s5_accepted", acc, 16);
    chk("s5_full", in_ready, 0);
    @(posedge clk);
    #1;
    axi_wready = 1;
    for (int c = 0; c < 20; c++) begin
      in_data = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("s5_idle", busy, 0);

    // Reset in the middle of the second burst
    do_reset();
    enable = 1; axi_awready = 1; axi_wready = 1;
    push_n(16, 0, 16'h0);
    wait_beats(11, "s6_wait");
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    chk("s6_awvalid", axi_awvalid, 0);
    chk("s6_wvalid", axi_wvalid, 0);
    chk("s6_wlast", axi_wlast, 0);
    chk("s6_busy", busy, 0);
    chk("s6_awaddr", axi_awaddr, BASE);
    chk("s6_bcount", burst_count, 0);
    chk("s6_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    chk("s6_rdy_pre_edge", in_ready, 0);
    @(negedge clk);
    chk("s6_rdy_post_edge", in_ready, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("s6_no_aw", aw_seen, 0);

`ifdef BRESP_WAIT_EN
    // Delayed write response gates the next burst
    do_reset();
    enable = 1; axi_awready = 1; axi_wready = 1;
    push_n(16, 0, 16'h0);
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("s7_aw_n", aw_log.size(), 2);
    chk("s7_bcount", burst_count, 2);
`endif

    // Random traffic against the model
    do_reset();
    stall_pct = 30;
    aw_stall = 30;
    auto_drv = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data = 16'($urandom);
      enable = $urandom_range(0, 7) != 0;
      reset = !($urandom_range(0, 599) == 0);
    end
    @(posedge clk);
    #1;
    reset = 1;
    in_valid = 0;
    enable = 1;
    stall_pct = 0;
    aw_stall = 0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("rand_drain_busy", busy, 0);
    chk("rand_drain_occ", occ < BL, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
